// File: rtl/decade_2421_sequencer_pkg.sv
// Shared definitions for the 2421 (Aiken) decade sequencer.
// Covers command opcodes, FSM states, digit constants and the digit validity test.
package decade_2421_sequencer_pkg;

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] D2421_ZERO = 4'b0000;
  localparam logic [3:0] D2421_FOUR = 4'b0100;
  localparam logic [3:0] D2421_FIVE = 4'b1011;
  localparam logic [3:0] D2421_NINE = 4'b1111;

  // Codes 0101..1010 have no meaning in 2421 and are rejected.
  function automatic logic digit_valid(input logic [3:0] d);
    return (d <= D2421_FOUR) || (d >= D2421_FIVE);
  endfunction

endpackage

// File: rtl/decade_2421_sequencer_if.sv
// Command and count bus between the front-panel logic and the sequencer.
// The master drives commands and ticks; the slave (sequencer) returns status.
interface decade_2421_sequencer_if #(
  parameter int NDIG = 2
);

  logic              tick;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [4*NDIG-1:0] cmd_data;
  logic [4*NDIG-1:0] count;
  logic              running;
  logic              done;
  logic              ovf;
  logic              err;

  modport master (
    output tick, cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, count, running, done, ovf, err
  );

  modport slave (
    input  tick, cmd_valid, cmd_op, cmd_data,
    output cmd_ready, count, running, done, ovf, err
  );

endinterface

// File: rtl/decade_2421_sequencer_inc.sv
// Single 2421 digit incrementer: next value and carry-out, purely combinational.
module digit_2421_inc
  import decade_2421_sequencer_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_carry,
  output logic [3:0] o_next,
  output logic       o_carry
);

  // 0100 jumps over the invalid gap to 1011; 1111 rolls to 0000 and carries.
  always_comb begin
    o_next = i_digit;
    if (i_carry) begin
      if (i_digit == D2421_NINE)
        o_next = D2421_ZERO;
      else if (i_digit == D2421_FOUR)
        o_next = D2421_FIVE;
      else
        o_next = i_digit + 4'd1;
    end
  end

  assign o_carry = i_carry && (i_digit == D2421_NINE);

endmodule

// File: rtl/decade_2421_sequencer.sv
// Command-driven controller for NDIG cascaded 2421 decade digits with
// limit detection, sticky wrap flag and rejected-command error pulse.
module decade_2421_sequencer
  import decade_2421_sequencer_pkg::*;
#(
  parameter int NDIG = 2
) (
  input logic                    clk,
  input logic                    reset,
  decade_2421_sequencer_if.slave bus
);

  state_t            r_state;
  logic [4*NDIG-1:0] r_count;
  logic [4*NDIG-1:0] r_limit;
  logic              r_ready;
  logic              r_running;
  logic              r_done;
  logic              r_ovf;
  logic              r_err;

  logic [4*NDIG-1:0] w_next;
  logic [NDIG:0]     w_carry;
  logic              w_data_valid;
  logic              w_accept;
  logic              w_hit;

  // Digit 0 always sees a carry-in; higher digits ripple in the same cycle.
  assign w_carry[0] = 1'b1;

  for (genvar g = 0; g < NDIG; g++) begin : g_digit
    digit_2421_inc u_inc (
      .i_digit (r_count[4*g +: 4]),
      .i_carry (w_carry[g]),
      .o_next  (w_next[4*g +: 4]),
      .o_carry (w_carry[g+1])
    );
  end

  always_comb begin
    w_data_valid = 1'b1;
    for (int k = 0; k < NDIG; k++) begin
      if (!digit_valid(bus.cmd_data[4*k +: 4]))
        w_data_valid = 1'b0;
    end
  end

  assign w_accept = bus.cmd_valid && r_ready;
  assign w_hit    = (w_next == r_limit);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_limit   <= '0;
      r_ready   <= 1'b1;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            case (bus.cmd_op)
              OP_START: begin
                if (w_data_valid) begin
                  r_limit   <= bus.cmd_data;
                  r_state   <= RUN;
                  r_running <= 1'b1;
                end else begin
                  r_err <= 1'b1;
                end
              end
              OP_LOAD: begin
                if (w_data_valid) r_count <= bus.cmd_data;
                else              r_err   <= 1'b1;
              end
              OP_CLEAR: begin
                r_count <= {NDIG{D2421_ZERO}};
                r_ovf   <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          // CLEAR beats a same-cycle tick; reaching the limit beats STOP.
          if (w_accept && bus.cmd_op == OP_CLEAR) begin
            r_count <= {NDIG{D2421_ZERO}};
            r_ovf   <= 1'b0;
          end else begin
            if (bus.tick) begin
              r_count <= w_next;
              if (w_carry[NDIG]) r_ovf <= 1'b1;
              if (w_hit) begin
                r_state   <= DONE;
                r_done    <= 1'b1;
                r_running <= 1'b0;
                r_ready   <= 1'b0;
              end
            end
            if (w_accept) begin
              if (bus.cmd_op == OP_STOP) begin
                if (!(bus.tick && w_hit)) begin
                  r_state   <= PAUSE;
                  r_running <= 1'b0;
                end
              end else begin
                r_err <= 1'b1;
              end
            end
          end
        end
        PAUSE: begin
          if (w_accept) begin
            case (bus.cmd_op)
              OP_START: begin
                r_state   <= RUN;
                r_running <= 1'b1;
              end
              OP_CLEAR: begin
                r_count <= {NDIG{D2421_ZERO}};
                r_ovf   <= 1'b0;
                r_state <= IDLE;
              end
              OP_LOAD: begin
                if (w_data_valid) r_count <= bus.cmd_data;
                else              r_err   <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = r_ready;
  assign bus.count     = r_count;
  assign bus.running   = r_running;
  assign bus.done      = r_done;
  assign bus.ovf       = r_ovf;
  assign bus.err       = r_err;

endmodule

// File: doc/decade_2421_sequencer.md
Name: decade_2421_sequencer

Overview:
Controller for a chain of NDIG cascaded 2421-code (Aiken) decade digits. It accepts start/stop/clear/load commands over a valid/ready handshake and advances the count on qualified `tick` pulses with ripple carry across digits. It signals completion when the count reaches a latched limit and flags wrap-around. It sits between the front-panel/command logic and the display/timer datapath that consumes `count`.

Parameters:
NDIG, 2, number of cascaded decade digits (1..4); count width is 4*NDIG.

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
tick  input  1  count-enable pulse; sampled only in RUN.
cmd_valid  input  1  command present.
cmd_ready  output  1  controller accepts command this cycle.
cmd_op  input  2  00 START, 01 STOP, 10 CLEAR, 11 LOAD.
cmd_data  input  4*NDIG  2421 value: the limit for START, the count for LOAD; digit 0 is bits [3:0].
count  output  4*NDIG  current count, 2421 per digit.
running  output  1  high in RUN.
done  output  1  one-cycle pulse when the limit is reached.
ovf  output  1  sticky; set on full wrap (all digits 1111 -> 0000).
err  output  1  one-cycle pulse on a rejected command.

Behaviour:
- Reset (synchronous, wins over everything): state=IDLE, count=0, limit=0, running=0, done=0, ovf=0, err=0, cmd_ready=1.
- Command handshake:
  - A command is accepted when cmd_valid && cmd_ready.
  - cmd_ready=0 only in DONE; a command held during DONE is accepted the next cycle.
- Valid 2421 digit codes: 0000-0100 and 1011-1111. Codes 0101-1010 are invalid.
- Digit increment:
  - 0100 -> 1011.
  - 1111 -> 0000 with carry into the next digit.
  - Otherwise, digit +1.
  - Digit k increments iff all lower digits are 1111 (single-cycle ripple).
- All outputs are registered. count updates the cycle after the tick is sampled.
- IDLE:
  - START: if cmd_data is all-valid, latch limit and go to RUN; otherwise err pulse and stay in IDLE.
  - LOAD: if valid, count=cmd_data; otherwise err pulse and count unchanged.
  - CLEAR: count=0, ovf=0.
  - STOP: no-op.
- RUN:
  - tick increments count. If the incremented value equals limit: go to DONE, done=1.
  - If the increment wraps all digits: ovf=1.
  - STOP: go to PAUSE.
  - CLEAR: count=0, ovf=0, remain in RUN.
  - START and LOAD: rejected, err pulse.
- PAUSE:
  - START: resume RUN with the limit retained (not relatched).
  - CLEAR: count=0, ovf=0, go to IDLE.
  - LOAD: apply as in IDLE, stay in PAUSE.
  - STOP: no-op.
- DONE: lasts exactly one cycle, then IDLE. count holds at limit.
- Simultaneous events in RUN:
  - tick + STOP: increment applied, then PAUSE.
  - tick + CLEAR: clear wins, no increment.
  - tick reaching limit + STOP: DONE wins.
- limit == count at START: done only after a full wrap returns to limit. ovf is set on the way.
- reset mid-RUN/PAUSE/DONE: immediate return to reset values; a pending done is suppressed.

Decomposition:
- Shared package holds:
  - cmd_op constants OP_START/OP_STOP/OP_CLEAR/OP_LOAD;
  - state encoding IDLE/RUN/PAUSE/DONE;
  - 2421 constants D2421_ZERO=0000, D2421_FOUR=0100, D2421_FIVE=1011, D2421_NINE=1111;
  - a function returning digit validity.
- One sub-module, `digit_2421_inc`: combinational single-digit next-value and carry-out. Instantiated NDIG times.
- The FSM, limit register and compare live in the top.

Test Plan:
- Reset with cmd_valid=1, op=START asserted -> after release: count=8'h00, running=0, ovf=0, cmd_ready=1, no err.
- LOAD 8'h04, START limit 8'h12, 3 ticks:
  - count 8'h0B (after 0100 -> 1011), then 8'h0C, 8'h0D.
  - 5 more ticks -> 8'h10, then 8'h11, then 8'h12 with done=1 for 1 cycle.
  - Next cycle IDLE with cmd_ready=1.
- LOAD 8'hFF, START limit 8'h02, 1 tick -> count 8'h00, ovf=1. 2 more ticks -> done. CLEAR -> ovf=0.
- START limit 8'h30, 2 ticks, then STOP together with a tick -> count 8'h03, PAUSE. Ticks ignored. START -> RUN resumes at 8'h03.
- Invalid codes:
  - LOAD 8'h07 -> err pulse, count unchanged.
  - START with limit 8'h60 -> err pulse, stays IDLE.
  - LOAD during RUN -> err pulse.
- Reset asserted while the count is one tick from limit in RUN -> count=0, IDLE, no done pulse.
